// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conversion job scheduler.
package conv_sched_pkg;

  localparam int DEF_N_WORDS     = 24;
  localparam int DEF_CALC_CYCLES = 2;
  localparam int WORD_IDX_W      = 8;
  localparam int CALC_CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    READ,
    CALC,
    STORE,
    COUNT,
    WRITE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/conv_job_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie, the requester not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic winner
);

  always_comb begin
    if (req0 && req1) begin
      winner = ~last_served;
    end else begin
      winner = req1;
    end
  end

endmodule

// File: rtl/conv_job_scheduler.sv
// Batch scheduler granting a shared conversion datapath to one of two requesters
// and sequencing read / calc / store per word, then a single file write.
module conv_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int N_WORDS     = DEF_N_WORDS,
  parameter int CALC_CYCLES = DEF_CALC_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  dp_sel,
  output logic                  dp_read,
  output logic                  dp_store,
  output logic                  dp_write,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic                  busy
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX  = WORD_IDX_W'(N_WORDS - 1);
  localparam logic [CALC_CNT_W-1:0] LAST_CALC = CALC_CNT_W'(CALC_CYCLES - 1);

  sched_state_t          state;
  sched_state_t          state_next;
  logic                  owner;
  logic                  last_served;
  logic                  winner;
  logic [CALC_CNT_W-1:0] calc_cnt;

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_served),
    .winner      (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_next = GRANT;
      GRANT:   state_next = READ;
      READ:    state_next = CALC;
      CALC:    if (calc_cnt == LAST_CALC) state_next = STORE;
      STORE:   state_next = COUNT;
      COUNT:   state_next = (word_idx == LAST_IDX) ? WRITE : READ;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Owner is captured only when leaving IDLE so grants stay stable for the whole batch;
  // word_idx is left at N_WORDS after the last COUNT and only cleared by the next GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      word_idx    <= '0;
      calc_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE:    if (req0 || req1) owner <= winner;
        GRANT:   word_idx <= '0;
        CALC:    calc_cnt <= (calc_cnt == LAST_CALC) ? '0 : calc_cnt + 1'b1;
        COUNT:   word_idx <= word_idx + 1'b1;
        DONE:    last_served <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    gnt0     = busy && !owner;
    gnt1     = busy && owner;
    dp_sel   = busy && owner;
    dp_read  = (state == READ);
    dp_store = (state == STORE);
    dp_write = (state == WRITE);
    done0    = (state == DONE) && !owner;
    done1    = (state == DONE) && owner;
  end

endmodule

// File: doc/conv_job_scheduler.md
CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 24, meaning words per conversion batch (legal range 1..255).
REQ-002 The block SHALL have parameter CALC_CYCLES, default 2, meaning datapath calculation latency in cycles (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have ports req0 and req1, input, 1 each, level batch requests from two requesters.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 each, meaning the datapath is owned by that requester.
REQ-007 The block SHALL have ports done0 and done1, output, 1 each, a one-cycle batch-complete pulse.
REQ-008 The block SHALL have port dp_sel, output, 1, selecting the datapath source: 0 for req0, 1 for req1.
REQ-009 The block SHALL have ports dp_read, dp_store and dp_write, output, 1 each, the datapath read, store-converted and write-file strobes.
REQ-010 The block SHALL have port word_idx, output, 8, the current word index within the batch.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The block SHALL use states IDLE, GRANT, READ, CALC, STORE, COUNT, WRITE and DONE, and every output SHALL decode from registered state only (Moore).
REQ-013 IDLE SHALL move to GRANT when req0 or req1 is sampled high, and SHALL otherwise stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: with one request, that request wins; with both, the requester not served last wins; last_served SHALL reset to 1 so req0 wins the first tie.
REQ-015 The winner SHALL be latched on the IDLE->GRANT edge, and gntN and dp_sel SHALL hold constant from GRANT through DONE inclusive.
REQ-016 GRANT SHALL clear word_idx and go to READ.
REQ-017 READ SHALL assert dp_read for 1 cycle and go to CALC.
REQ-018 CALC SHALL last exactly CALC_CYCLES cycles, counted by an internal counter, then go to STORE.
REQ-019 STORE SHALL assert dp_store for 1 cycle and go to COUNT.
REQ-020 COUNT SHALL increment word_idx; it SHALL go to WRITE if the pre-increment word_idx equals N_WORDS-1, and otherwise return to READ.
REQ-021 WRITE SHALL assert dp_write for 1 cycle and go to DONE.
REQ-022 DONE SHALL pulse doneN of the granted requester for 1 cycle, update last_served, and return to IDLE.
REQ-023 Batch length from entering GRANT to leaving DONE SHALL be 3 + N_WORDS*(3+CALC_CYCLES) cycles, which is 123 at the defaults.
REQ-024 A request deasserted mid-batch SHALL be ignored, and the batch SHALL run to completion.
REQ-025 A request that stays high through DONE SHALL be re-arbitrated in IDLE, giving at least one idle cycle between batches.
REQ-026 At most one of dp_read, dp_store, dp_write, done0 and done1 SHALL be high in any cycle.
REQ-027 word_idx SHALL never exceed N_WORDS, and SHALL hold its final value from WRITE until the next GRANT.

Reset
REQ-028 On rst, the state SHALL become IDLE immediately, independent of clk.
REQ-029 On rst, gnt0, gnt1, done0, done1, dp_read, dp_store, dp_write and busy SHALL be 0, dp_sel SHALL be 0, word_idx SHALL be 0, the CALC counter SHALL be 0, and last_served SHALL be 1.
REQ-030 Reset asserted in any state mid-batch SHALL abort the batch without a done pulse, and no dp_write SHALL be issued.

Structure
REQ-031 Package conv_sched_pkg SHALL hold the state enum, default N_WORDS and CALC_CYCLES constants, and the word_idx width constant.
REQ-032 Sub-module rr_arb2 SHALL implement the two-input round-robin grant logic, with inputs req0, req1 and last_served, and output winner; the FSM SHALL remain in conv_job_scheduler.

Verification
REQ-033 Scenario: req0 held, defaults -> gnt0 for 123 cycles, 24 dp_read, 24 dp_store, 1 dp_write, done0 pulses exactly once, word_idx ends at 24.
REQ-034 Scenario: req0 and req1 raised together from reset -> req0 is served first; on the next batch req1 is served, and batches alternate while both are held.
REQ-035 Scenario: req1 dropped 10 cycles after grant -> the batch still completes, done1 pulses, and the block returns to IDLE.
REQ-036 Scenario: N_WORDS=1, CALC_CYCLES=1 -> batch of 7 cycles, sequence GRANT,READ,CALC,STORE,COUNT,WRITE,DONE.
REQ-037 Scenario: rst pulsed during word 5 CALC -> all outputs are 0 immediately, no done or dp_write occurs, and the next req restarts at word_idx 0.
REQ-038 Scenario: every cycle -> assertion check of the one-hot strobes, gnt0&gnt1==0, and busy==(state!=IDLE).
